// File: rtl/uart_tx_stream_arbiter.sv
// Round-robin arbiter that shares one UART TX stream between two byte requesters.
// A grant is held for a whole packet (or until the burst limit), then an optional idle gap follows.
module uart_tx_stream_arbiter #(
  parameter int DATA_W     = 8,
  parameter int MAX_BURST  = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s0_valid,
  output logic              s0_ready,
  input  logic [DATA_W-1:0] s0_payload,
  input  logic              s0_last,
  input  logic              s1_valid,
  output logic              s1_ready,
  input  logic [DATA_W-1:0] s1_payload,
  input  logic              s1_last,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] tx_payload,
  output logic [1:0]        grant,
  output logic              busy
);

  localparam int BCW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BCW-1:0] BURST_END = BCW'(MAX_BURST - 1);
  localparam logic [GCW-1:0] GAP_LOAD  = GCW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e             state_q;
  logic [1:0]         grant_q;
  logic [BCW-1:0]     burst_cnt_q;
  logic [GCW-1:0]     gap_cnt_q;
  logic               last_winner_q;

  logic               sel_valid;
  logic               sel_last;
  logic [DATA_W-1:0]  sel_payload;
  logic               in_busy;
  logic               xfer;
  logic               release_d;
  logic               winner_d;

  always_comb begin
    sel_valid   = grant_q[1] ? s1_valid   : s0_valid;
    sel_last    = grant_q[1] ? s1_last    : s0_last;
    sel_payload = grant_q[1] ? s1_payload : s0_payload;
  end

  // Gating with reset keeps a byte offered during the reset cycle from being accepted.
  assign in_busy    = (state_q == BUSY) && !reset;
  assign tx_valid   = in_busy && sel_valid;
  assign tx_payload = in_busy ? sel_payload : '0;
  assign s0_ready   = in_busy && grant_q[0] && tx_ready;
  assign s1_ready   = in_busy && grant_q[1] && tx_ready;

  assign xfer      = tx_valid && tx_ready;
  assign release_d = xfer && (sel_last || (burst_cnt_q == BURST_END));
  // On a tie the source that did not win last time goes first.
  assign winner_d  = (s0_valid && s1_valid) ? ~last_winner_q : s1_valid;

  assign grant = grant_q;
  assign busy  = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= 2'b00;
      burst_cnt_q   <= '0;
      gap_cnt_q     <= '0;
      last_winner_q <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (s0_valid || s1_valid) begin
            grant_q <= winner_d ? 2'b10 : 2'b01;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (release_d) begin
            last_winner_q <= grant_q[1];
            burst_cnt_q   <= '0;
            grant_q       <= 2'b00;
            if (GAP_CYCLES == 0) begin
              state_q <= IDLE;
            end else begin
              state_q   <= GAP;
              gap_cnt_q <= GAP_LOAD;
            end
          end else if (xfer) begin
            burst_cnt_q <= burst_cnt_q + BCW'(1);
          end
        end
        GAP: begin
          if (gap_cnt_q == '0) begin
            state_q <= IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q - GCW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_stream_arbiter.sv
// Bench for uart_tx_stream_arbiter: directed timing checks plus randomized packet traffic
// scored against a packet-level arbitration model.
module tb_uart_tx_stream_arbiter;

  localparam int DW    = 8;
  localparam int MB_A  = 16;
  localparam int GAP_A = 2;
  localparam int MB_B  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          a_reset = 1'b1;
  logic          a_s0_valid = 1'b0, a_s0_last = 1'b0, a_s1_valid = 1'b0, a_s1_last = 1'b0;
  logic          a_tx_ready = 1'b0;
  logic [DW-1:0] a_s0_payload = '0, a_s1_payload = '0;
  logic          a_s0_ready, a_s1_ready, a_tx_valid, a_busy;
  logic [DW-1:0] a_tx_payload;
  logic [1:0]    a_grant;

  logic          b_reset = 1'b1;
  logic          b_s0_valid = 1'b0, b_s0_last = 1'b0, b_s1_valid = 1'b0, b_s1_last = 1'b0;
  logic          b_tx_ready = 1'b0;
  logic [DW-1:0] b_s0_payload = '0, b_s1_payload = '0;
  logic          b_s0_ready, b_s1_ready, b_tx_valid, b_busy;
  logic [DW-1:0] b_tx_payload;
  logic [1:0]    b_grant;

  uart_tx_stream_arbiter #(.DATA_W(DW), .MAX_BURST(MB_A), .GAP_CYCLES(GAP_A)) dut_a (
    .clk(clk), .reset(a_reset),
    .s0_valid(a_s0_valid), .s0_ready(a_s0_ready), .s0_payload(a_s0_payload), .s0_last(a_s0_last),
    .s1_valid(a_s1_valid), .s1_ready(a_s1_ready), .s1_payload(a_s1_payload), .s1_last(a_s1_last),
    .tx_valid(a_tx_valid), .tx_ready(a_tx_ready), .tx_payload(a_tx_payload),
    .grant(a_grant), .busy(a_busy)
  );

  uart_tx_stream_arbiter #(.DATA_W(DW), .MAX_BURST(MB_B), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .reset(b_reset),
    .s0_valid(b_s0_valid), .s0_ready(b_s0_ready), .s0_payload(b_s0_payload), .s0_last(b_s0_last),
    .s1_valid(b_s1_valid), .s1_ready(b_s1_ready), .s1_payload(b_s1_payload), .s1_last(b_s1_last),
    .tx_valid(b_tx_valid), .tx_ready(b_tx_ready), .tx_payload(b_tx_payload),
    .grant(b_grant), .busy(b_busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Queue entries are {last, payload} for sources and {src, payload} for the scoreboard.
  logic [8:0] sq0[$], sq1[$], bq0[$], bq1[$], mq0[$], mq1[$];
  logic [8:0] exp_q[$];
  int         seg_src_q[$], seg_len_q[$];
  int         m_lw;
  bit         mon_en = 1'b0;
  logic       acc0 = 1'b0, acc1 = 1'b0;

  function automatic void chk(string nm, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
    end
  endfunction

  function automatic void dir_row(string nm, int g, int b, int tv, int pay);
    chk({nm, "_grant"}, a_grant, g);
    chk({nm, "_busy"}, a_busy, b);
    chk({nm, "_txvalid"}, a_tx_valid, tv);
    chk({nm, "_payload"}, a_tx_payload, pay);
  endfunction

  function automatic void gen_pkts(int src, int npk, int lo, int hi, bit to_b);
    int len;
    logic [8:0] e;
    for (int p = 0; p < npk; p++) begin
      len = $urandom_range(hi, lo);
      for (int k = 0; k < len; k++) begin
        e = {(k == len - 1), 8'($urandom)};
        if (src == 0) begin
          mq0.push_back(e);
          if (to_b) bq0.push_back(e); else sq0.push_back(e);
        end else begin
          mq1.push_back(e);
          if (to_b) bq1.push_back(e); else sq1.push_back(e);
        end
      end
    end
  endfunction

  // Packet-level reference: both sources offer continuously, so each grant is decided by
  // who still has data and by the round-robin pointer; a grant ends at 'last' or the burst limit.
  function automatic void model_run(int maxb);
    int w, n;
    logic [8:0] b;
    while (mq0.size() > 0 || mq1.size() > 0) begin
      if (mq0.size() > 0 && mq1.size() > 0) w = (m_lw == 0) ? 1 : 0;
      else if (mq0.size() > 0) w = 0;
      else w = 1;
      n = 0;
      do begin
        b = (w == 0) ? mq0.pop_front() : mq1.pop_front();
        exp_q.push_back({w[0], b[7:0]});
        n++;
      end while (!b[8] && n < maxb && ((w == 0) ? mq0.size() : mq1.size()) > 0);
      seg_src_q.push_back(w);
      seg_len_q.push_back(n);
      m_lw = w;
    end
  endfunction

  task automatic drive_a();
    @(posedge clk);
    #1;
    if (acc0 && sq0.size() > 0) void'(sq0.pop_front());
    if (acc1 && sq1.size() > 0) void'(sq1.pop_front());
    if (acc0 || !a_s0_valid)
      a_s0_valid = (sq0.size() > 0) && (a_grant != 2'b01 || $urandom_range(3, 0) != 0);
    if (acc1 || !a_s1_valid)
      a_s1_valid = (sq1.size() > 0) && (a_grant != 2'b10 || $urandom_range(3, 0) != 0);
    if (sq0.size() > 0) begin a_s0_payload = sq0[0][7:0]; a_s0_last = sq0[0][8]; end
    if (sq1.size() > 0) begin a_s1_payload = sq1[0][7:0]; a_s1_last = sq1[0][8]; end
    a_tx_ready = ($urandom_range(9, 0) < 7);
  endtask

  task automatic round_begin();
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    a_reset = 1'b1;
    a_s0_valid = 1'b0;
    a_s1_valid = 1'b0;
    a_tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    a_reset = 1'b0;
    sq0.delete(); sq1.delete(); mq0.delete(); mq1.delete();
    exp_q.delete(); seg_src_q.delete(); seg_len_q.delete();
    m_lw = 1;
  endtask

  task automatic round_run(string nm);
    int cyc;
    model_run(MB_A);
    mon_en = 1'b1;
    cyc = 0;
    while ((exp_q.size() > 0 || sq0.size() > 0 || sq1.size() > 0) && cyc < 5000) begin
      drive_a();
      cyc++;
    end
    chk({nm, "_completed"}, int'(cyc < 5000), 1);
    repeat (4) drive_a();
    mon_en = 1'b0;
    chk({nm, "_leftover"}, exp_q.size(), 0);
    exp_q.delete(); sq0.delete(); sq1.delete();
    a_s0_valid = 1'b0;
    a_s1_valid = 1'b0;
  endtask

  // Monitor: scores every transfer of dut_a against the model queue and checks stream rules.
  initial begin : monitor
    logic [1:0] pg;
    logic       pstall;
    logic [7:0] ppay;
    int         zrun;
    bit         seen, allv;
    logic [8:0] e;
    pg = '0; pstall = 1'b0; ppay = '0; zrun = 0; seen = 1'b0; allv = 1'b1;
    forever begin
      @(negedge clk);
      acc0 = a_s0_valid && a_s0_ready;
      acc1 = a_s1_valid && a_s1_ready;
      if (!mon_en || a_reset) begin
        pg = '0; pstall = 1'b0; zrun = 0; seen = 1'b0; allv = 1'b1;
      end else begin
        if (a_grant == 2'b00) begin
          chk("nogrant_txvalid", a_tx_valid, 0);
          zrun++;
          allv = allv && (a_s0_valid || a_s1_valid);
        end else begin
          if (pg == 2'b00 && seen && allv) chk("gap_len", zrun, GAP_A + 1);
          zrun = 0; allv = 1'b1; seen = 1'b1;
          chk("other_ready", a_grant[0] ? a_s1_ready : a_s0_ready, 0);
        end
        if (pstall) begin
          chk("stall_valid", a_tx_valid, 1);
          chk("stall_payload", a_tx_payload, ppay);
        end
        if (a_tx_valid && a_tx_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_xfer", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("owner", a_grant, e[8] ? 2 : 1);
            chk("payload", a_tx_payload, e[7:0]);
            chk("src_ready", e[8] ? a_s1_ready : a_s0_ready, 1);
          end
        end
        pstall = a_tx_valid && !a_tx_ready;
        ppay   = a_tx_payload;
        pg     = a_grant;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int eg1[7]  = '{0, 1, 1, 1, 0, 0, 0};
    int eb1[7]  = '{0, 1, 1, 1, 1, 1, 0};
    int etv1[7] = '{0, 1, 1, 1, 0, 0, 0};
    int ep1[7]  = '{0, 'hA1, 'hA2, 'hA3, 0, 0, 0};
    int eg5[7]  = '{0, 1, 0, 0, 0, 2, 0};
    int eb5[7]  = '{0, 1, 1, 1, 0, 1, 1};
    int etv5[7] = '{0, 1, 0, 0, 0, 1, 0};
    int ep5[7]  = '{0, 'hF1, 0, 0, 0, 'hE1, 0};
    int trace[$];
    logic bacc0, bacc1;
    logic [8:0] e;

    // Reset state, with a request already pending at the inputs.
    a_s0_valid = 1'b1; a_s0_payload = 8'h5A; a_tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    dir_row("reset", 0, 0, 0, 0);
    chk("reset_s0_ready", a_s0_ready, 0);
    chk("reset_s1_ready", a_s1_ready, 0);

    // Single 3-byte packet from s0: one arbitration cycle, 3 bytes, 2 gap cycles.
    @(posedge clk);
    #1;
    a_reset = 1'b0; b_reset = 1'b0;
    a_s0_valid = 1'b1; a_s0_payload = 8'hA1; a_s0_last = 1'b0; a_tx_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      dir_row($sformatf("pkt3_c%0d", c), eg1[c], eb1[c], etv1[c], ep1[c]);
      @(posedge clk);
      #1;
      if (c == 1) a_s0_payload = 8'hA2;
      if (c == 2) begin a_s0_payload = 8'hA3; a_s0_last = 1'b1; end
      if (c == 3) a_s0_valid = 1'b0;
    end

    // Reset in the middle of a 4-byte packet, then a tie and a lone requester.
    a_s0_valid = 1'b1; a_s0_payload = 8'hD1; a_s0_last = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_d1", a_tx_payload, 'hD1);
    @(posedge clk); #1;
    a_s0_payload = 8'hD2;
    @(negedge clk);
    chk("mid_d2", a_tx_payload, 'hD2);
    @(posedge clk); #1;
    a_s0_payload = 8'hD3;
    a_reset = 1'b1;
    @(negedge clk);
    chk("rst_s0_ready", a_s0_ready, 0);
    chk("rst_txvalid", a_tx_valid, 0);
    @(posedge clk); #1;
    a_reset = 1'b0;
    a_s0_payload = 8'hF1; a_s0_last = 1'b1;
    a_s1_valid = 1'b1; a_s1_payload = 8'hE1; a_s1_last = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      dir_row($sformatf("postrst_c%0d", c), eg5[c], eb5[c], etv5[c], ep5[c]);
      @(posedge clk);
      #1;
      if (c == 1) a_s0_valid = 1'b0;
      if (c == 5) a_s1_valid = 1'b0;
    end

    // Randomized traffic scored by the monitor.
    round_begin();
    gen_pkts(0, 4, 1, 5, 1'b0);
    gen_pkts(1, 4, 1, 5, 1'b0);
    round_run("alt");

    round_begin();
    gen_pkts(1, 1, 20, 20, 1'b0);
    gen_pkts(0, 2, 3, 3, 1'b0);
    round_run("burst");

    round_begin();
    gen_pkts(0, 6, 1, 20, 1'b0);
    gen_pkts(1, 6, 1, 20, 1'b0);
    round_run("mix");

    round_begin();
    gen_pkts(0, 3, 1, 18, 1'b0);
    round_run("solo");

    // Zero-gap instance: packets separated only by the arbitration cycle.
    mq0.delete(); mq1.delete(); exp_q.delete(); seg_src_q.delete(); seg_len_q.delete();
    m_lw = 1;
    gen_pkts(0, 1, 2, 2, 1'b1);
    gen_pkts(0, 1, 5, 5, 1'b1);
    gen_pkts(1, 1, 2, 2, 1'b1);
    model_run(MB_B);
    trace.push_back(0);
    for (int i = 0; i < seg_src_q.size(); i++) begin
      for (int k = 0; k < seg_len_q[i]; k++) trace.push_back(seg_src_q[i] != 0 ? 2 : 1);
      trace.push_back(0);
    end
    b_tx_ready = 1'b1;
    bacc0 = 1'b0;
    bacc1 = 1'b0;
    for (int k = 0; k < trace.size(); k++) begin
      @(posedge clk);
      #1;
      if (bacc0 && bq0.size() > 0) void'(bq0.pop_front());
      if (bacc1 && bq1.size() > 0) void'(bq1.pop_front());
      b_s0_valid = (bq0.size() > 0);
      b_s1_valid = (bq1.size() > 0);
      if (bq0.size() > 0) begin b_s0_payload = bq0[0][7:0]; b_s0_last = bq0[0][8]; end
      if (bq1.size() > 0) begin b_s1_payload = bq1[0][7:0]; b_s1_last = bq1[0][8]; end
      @(negedge clk);
      chk($sformatf("gap0_grant_c%0d", k), b_grant, trace[k]);
      if (b_tx_valid) begin
        if (exp_q.size() == 0) begin
          chk("gap0_unexpected_xfer", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("gap0_owner", b_grant, e[8] ? 2 : 1);
          chk("gap0_payload", b_tx_payload, e[7:0]);
        end
      end
      bacc0 = b_s0_valid && b_s0_ready;
      bacc1 = b_s1_valid && b_s1_ready;
    end
    chk("gap0_leftover", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
